vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder_pkg.sv | 19 +
 rtl/vga_line_checker.sv | 43 ++++
 rtl/vga_sync_decoder.sv | 133 +++++++++++++
 tb/tb_vga_sync_decoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA timing defaults and the sync-decoder FSM state encoding.
// Intended to be imported by every VGA block (vga_640x480, vga_sync_decoder).
package vga_sync_decoder_pkg;
  localparam int H_TOTAL_D     = 800;
  localparam int V_TOTAL_D     = 521;
  localparam int H_SYNC_D      = 96;
  localparam int V_SYNC_D      = 2;
  localparam int HBP_D         = 144;
  localparam int HFP_D         = 784;
  localparam int VBP_D         = 31;
  localparam int VFP_D         = 511;
  localparam int LOCK_FRAMES_D = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_e;
endpackage

// File: rtl/vga_line_checker.sv
// Hsync edge detection, horizontal pixel counter and per-line interval/width check.
module vga_line_checker #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hsync,
  output logic [9:0] o_hc,
  output logic       o_line_start,
  output logic       o_line_bad
);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_M1 = 10'(H_SYNC - 1);

  logic       r_hs;
  logic [9:0] r_hc;
  logic       w_fall, w_rise, w_bad_int, w_overrun, w_bad_wid;

  assign w_fall    = r_hs & ~i_hsync;
  assign w_rise    = ~r_hs & i_hsync;
  assign w_bad_int = w_fall & (r_hc != HT_M1);
  // Flag the overrun one edge early so the registered error lands as hc reaches H_TOTAL.
  assign w_overrun = ~w_fall & (r_hc == HT_M1);
  assign w_bad_wid = w_rise & (r_hc != HS_M1);

  assign o_hc         = r_hc;
  assign o_line_start = w_fall;
  assign o_line_bad   = w_bad_int | w_overrun | w_bad_wid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs <= 1'b1;
      r_hc <= '0;
    end else begin
      r_hs <= i_hsync;
      if (w_fall)
        r_hc <= '0;
      else if (r_hc != 10'h3FF)
        r_hc <= r_hc + 10'd1;
    end
  end
endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers hc/vc from incoming Hsync/Vsync, validates timing and locks after
// LOCK_FRAMES consecutive good frames.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_D,
  parameter int V_TOTAL     = V_TOTAL_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int HBP         = HBP_D,
  parameter int HFP         = HFP_D,
  parameter int VBP         = VBP_D,
  parameter int VFP         = VFP_D,
  parameter int LOCK_FRAMES = LOCK_FRAMES_D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Hsync,
  input  logic       Vsync,
  output logic [9:0] hc_o,
  output logic [9:0] vc_o,
  output logic       vidon_o,
  output logic       locked_o,
  output logic       err_o,
  output logic       frame_o
);
  localparam logic [9:0] VT    = 10'(V_TOTAL);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_W  = 10'(V_SYNC);

  logic [9:0]  w_hc;
  logic        w_hs_fall, w_line_bad;
  logic        w_vs_fall, w_vs_rise, w_frame_bad, w_bad;
  logic        r_vs;
  logic [9:0]  r_vc, r_fcnt, r_vlow;
  logic [7:0]  r_good;
  logic        r_locked, r_err, r_frame;
  sync_state_e r_state;

  vga_line_checker #(.H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC)) u_line (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hsync      (Hsync),
    .o_hc         (w_hc),
    .o_line_start (w_hs_fall),
    .o_line_bad   (w_line_bad)
  );

  assign w_vs_fall   = r_vs & ~Vsync;
  assign w_vs_rise   = ~r_vs & Vsync;
  assign w_frame_bad = (w_vs_fall & (r_fcnt != VT)) | (w_vs_rise & (r_vlow != VS_W));
  assign w_bad       = w_line_bad | w_frame_bad;

  assign hc_o     = w_hc;
  assign vc_o     = r_vc;
  assign locked_o = r_locked;
  assign err_o    = r_err;
  assign frame_o  = r_frame;
  assign vidon_o  = r_locked & (w_hc > 10'(HBP)) & (w_hc < 10'(HFP))
                             & (r_vc > 10'(VBP)) & (r_vc < 10'(VFP));

  // Vertical counter and frame-level measurements run regardless of lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs    <= 1'b1;
      r_vc    <= '0;
      r_fcnt  <= '0;
      r_vlow  <= '0;
      r_frame <= 1'b0;
    end else begin
      r_vs    <= Vsync;
      r_frame <= w_vs_fall;

      if (w_vs_fall)
        r_vc <= '0;
      else if (w_hs_fall)
        r_vc <= (r_vc == VT_M1) ? '0 : r_vc + 10'd1;

      // A line start coinciding with the Vsync fall belongs to the new frame.
      if (w_vs_fall)
        r_fcnt <= {9'd0, w_hs_fall};
      else if (w_hs_fall && r_fcnt != 10'h3FF)
        r_fcnt <= r_fcnt + 10'd1;

      if (w_vs_fall)
        r_vlow <= {9'd0, w_hs_fall};
      else if (w_hs_fall && !Vsync && r_vlow != 10'h3FF)
        r_vlow <= r_vlow + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_SEARCH;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_vs_fall) begin
            r_state <= ST_ALIGN;
            r_good  <= '0;
          end
        end
        ST_ALIGN: begin
          if (w_bad) begin
            r_state <= ST_SEARCH;
          end else if (w_vs_fall) begin
            if (int'(r_good) + 1 >= LOCK_FRAMES) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_good <= r_good + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 40x20 timing.
module tb_vga_sync_decoder;
  localparam int HT = 40, VT = 20, HS = 6, VS = 2;
  localparam int HBP = 8, HFP = 36, VBP = 3, VFP = 18, LF = 2;

  typedef struct {
    int l; int p;
    int hc; int vc; int vid; int frm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Hsync = 1'b1;
  logic       Vsync = 1'b1;
  logic [9:0] hc_o, vc_o;
  logic       vidon_o, locked_o, err_o, frame_o;

  int   nchk = 0, nerr = 0;
  int   cur_l = 0, cur_p = 0;
  bit   tbl_en = 1'b0;
  int   err_cnt = 0, e_hc = -1, e_lk = -1, e_l = -1, e_p = -1;
  int   trk_bad = 0, vid_cnt = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Hsync(Hsync), .Vsync(Vsync),
    .hc_o(hc_o), .vc_o(vc_o), .vidon_o(vidon_o),
    .locked_o(locked_o), .err_o(err_o), .frame_o(frame_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One pixel clock: drive at negedge, sample 1 ns after the rising edge.
  task automatic tick(input bit hs, input bit vs, input bit rst, input int l, input int p);
    @(negedge clk);
    Hsync = hs; Vsync = vs; rst_n = ~rst; cur_l = l; cur_p = p;
    @(posedge clk);
    #1;
    if (err_o) begin
      err_cnt++;
      e_hc = int'(hc_o); e_lk = int'(locked_o); e_l = l; e_p = p;
    end
    if (rst) begin
      chk("mrst_hc", int'(hc_o), 0);
      chk("mrst_vc", int'(vc_o), 0);
      chk("mrst_vidon", int'(vidon_o), 0);
      chk("mrst_locked", int'(locked_o), 0);
      chk("mrst_err", int'(err_o), 0);
      chk("mrst_frame", int'(frame_o), 0);
    end
    if (tbl_en) begin
      foreach (tbl[i]) begin
        if (tbl[i].l == l && tbl[i].p == p) begin
          chk($sformatf("tbl%0d_hc", i), int'(hc_o), tbl[i].hc);
          chk($sformatf("tbl%0d_vc", i), int'(vc_o), tbl[i].vc);
          chk($sformatf("tbl%0d_vidon", i), int'(vidon_o), tbl[i].vid);
          chk($sformatf("tbl%0d_frame", i), int'(frame_o), tbl[i].frm);
        end
      end
      if (int'(hc_o) != p || int'(vc_o) != l) trk_bad++;
      if (vidon_o) vid_cnt++;
    end
  endtask

  // nl lines; line bl gets length blen and sync width bsw; reset pulse at (rl,10).
  task automatic frame(input int nl, input int bl, input int blen, input int bsw, input int rl);
    for (int l = 0; l < nl; l++) begin
      int len, sw;
      len = (l == bl) ? blen : HT;
      sw  = (l == bl) ? bsw : HS;
      for (int p = 0; p < len; p++)
        tick(p >= sw, l >= VS, (l == rl) && (p == 10), l, p);
    end
  endtask

  task automatic good_frames(input int n);
    for (int k = 0; k < n; k++) frame(VT, -1, 0, 0, -1);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 1, 0, 0, 0};
    tbl[2]  = '{5, 8, 8, 5, 0, 0};
    tbl[3]  = '{5, 9, 9, 5, 1, 0};
    tbl[4]  = '{5, 35, 35, 5, 1, 0};
    tbl[5]  = '{5, 36, 36, 5, 0, 0};
    tbl[6]  = '{3, 20, 20, 3, 0, 0};
    tbl[7]  = '{4, 20, 20, 4, 1, 0};
    tbl[8]  = '{17, 20, 20, 17, 1, 0};
    tbl[9]  = '{18, 20, 20, 18, 0, 0};
    tbl[10] = '{19, 39, 39, 19, 0, 0};
    tbl[11] = '{10, 5, 5, 10, 0, 0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hc", int'(hc_o), 0);
    chk("rst_vc", int'(vc_o), 0);
    chk("rst_vidon", int'(vidon_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_frame", int'(frame_o), 0);

    // Lock acquisition: ALIGN at 1st Vsync fall, LOCKED at the 3rd.
    good_frames(2);
    chk("lock_wait", int'(locked_o), 0);
    tbl_en = 1'b1;
    good_frames(1);
    tbl_en = 1'b0;
    chk("locked_3f", int'(locked_o), 1);
    chk("vidon_count", vid_cnt, (HFP - HBP - 1) * (VFP - VBP - 1));
    chk("track_hc_vc", trk_bad, 0);
    chk("no_err_lock", err_cnt, 0);

    // Line 7 stretched to HT+1 clocks.
    frame(VT, 7, HT + 1, HS, -1);
    chk("str_err_cnt", err_cnt, 1);
    chk("str_err_hc", e_hc, HT);
    chk("str_err_locked", e_lk, 0);
    chk("str_err_pos", e_l * 100 + e_p, 7 * 100 + HT);
    good_frames(2);
    chk("str_relock_wait", int'(locked_o), 0);
    good_frames(1);
    chk("str_relock", int'(locked_o), 1);
    chk("str_err_once", err_cnt, 1);

    // Hsync low width one short on line 4.
    frame(VT, 4, HT, HS - 1, -1);
    chk("wid_err_cnt", err_cnt, 2);
    chk("wid_err_locked", e_lk, 0);
    chk("wid_err_pos", e_l * 100 + e_p, 4 * 100 + (HS - 1));
    good_frames(3);
    chk("wid_relock", int'(locked_o), 1);

    // Frame one line short: error lands on the closing Vsync fall.
    frame(VT - 1, -1, 0, 0, -1);
    chk("short_no_err_yet", err_cnt, 2);
    good_frames(1);
    chk("short_err_cnt", err_cnt, 3);
    chk("short_err_pos", e_l * 100 + e_p, 0);
    chk("short_err_locked", e_lk, 0);
    good_frames(3);
    chk("short_relock", int'(locked_o), 1);

    // One-cycle reset mid-frame while locked.
    frame(VT, -1, 0, 0, 10);
    chk("mrst_no_err", err_cnt, 3);
    chk("mrst_unlocked", int'(locked_o), 0);
    good_frames(3);
    chk("mrst_relock", int'(locked_o), 1);
    chk("final_err_cnt", err_cnt, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
